// File: rtl/mem_stage_axi.sv
// Memory stage with an AXI4-Lite master port.
// Turns a load or store from EX/MEM into one AXI4-Lite transaction and stalls the pipeline
// until the transaction completes. A store drives AW and W together. A load drives AR and
// then waits for R. The captured word is formatted for LB/LH/LW/LBU/LHU.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword and word accesses.
// A trapped access issues no bus transaction and pulses misaligned.

module mem_stage_axi #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           result,
  input  logic [31:0]           op2_data,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [1:0]            store_type,
  input  logic [2:0]            load_type,
  output logic [31:0]           read_data,
  output logic [31:0]           calculated_result,
  output logic                  stall,
  output logic                  bus_error,
  output logic                  misaligned,
  // AXI4-Lite write channels
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // AXI4-Lite read channels
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWr   = 3'd1,
    StWb   = 3'd2,
    StRa   = 3'd3,
    StRd   = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam logic [1:0] StSb = 2'b00;
  localparam logic [1:0] StSh = 2'b01;
  localparam logic [2:0] LdLb  = 3'b000;
  localparam logic [2:0] LdLh  = 3'b001;
  localparam logic [2:0] LdLw  = 3'b010;
  localparam logic [2:0] LdLbu = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;

  state_e r_state, w_state_d;

  // Transaction context captured when leaving IDLE
  logic [ADDR_WIDTH-1:2] r_addr;
  logic [1:0]            r_off;
  logic [2:0]            r_load_type;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_aw_pend;
  logic                  r_w_pend;
  logic [1:0]            r_resp;

  // Read result context. It is kept apart from r_off/r_load_type, so a later store
  // cannot disturb read_data.
  logic [31:0]           r_rword;
  logic [1:0]            r_rd_off;
  logic [2:0]            r_rd_ltype;

  logic                  w_start_wr;
  logic                  w_start_rd;
  logic                  w_start_trap;
  logic                  w_mis;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic [31:0]           w_wdata_fmt;
  logic [3:0]            w_wstrb_fmt;
  logic [31:0]           w_shift;
  logic [15:0]           w_half;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis;

  // Flags halfword accesses on an odd byte and word accesses that are not word-aligned.
  always_comb begin
    if (mem_write) begin
      w_mis = ((store_type == StSh) && result[0]) ||
              ((store_type == 2'b10) && (result[1:0] != 2'b00));
    end else begin
      w_mis = (((load_type == LdLh) || (load_type == LdLhu)) && result[0]) ||
              ((load_type == LdLw) && (result[1:0] != 2'b00));
    end
  end

  assign misaligned = (r_state == StDone) && r_mis;
`else
  assign w_mis      = 1'b0;
  assign misaligned = 1'b0;
`endif

  // A channel counts as done once its handshake has happened, whether in this cycle or earlier.
  assign w_aw_done = ~r_aw_pend | m_awready;
  assign w_w_done  = ~r_w_pend | m_wready;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic. A write has priority over a read.
  always_comb begin
    w_state_d    = r_state;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    w_start_trap = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mem_write || mem_read) begin
          if (w_mis) begin
            w_state_d    = StDone;
            w_start_trap = 1'b1;
          end else if (mem_write) begin
            w_state_d  = StWr;
            w_start_wr = 1'b1;
          end else begin
            w_state_d  = StRa;
            w_start_rd = 1'b1;
          end
        end
      end
      StWr:    if (w_aw_done && w_w_done) w_state_d = StWb;
      StWb:    if (m_bvalid) w_state_d = StDone;
      StRa:    if (m_arready) w_state_d = StRd;
      StRd:    if (m_rvalid) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Store lane replication and byte strobes
  always_comb begin
    w_wdata_fmt = op2_data;
    w_wstrb_fmt = 4'b1111;
    unique case (store_type)
      StSb: begin
        w_wdata_fmt = {4{op2_data[7:0]}};
        w_wstrb_fmt = 4'b0001 << result[1:0];
      end
      StSh: begin
        w_wdata_fmt = {2{op2_data[15:0]}};
        w_wstrb_fmt = 4'b0011 << {result[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Transaction context, handshake tracking and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_off       <= 2'b00;
      r_load_type <= 3'b000;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'b0000;
      r_aw_pend   <= 1'b0;
      r_w_pend    <= 1'b0;
      r_resp      <= 2'b00;
      r_rword     <= 32'h0;
      r_rd_off    <= 2'b00;
      r_rd_ltype  <= 3'b000;
`ifdef MEM_MISALIGN_TRAP_EN
      r_mis       <= 1'b0;
`endif
    end else begin
      if (w_start_wr || w_start_rd) begin
        r_addr      <= result[ADDR_WIDTH-1:2];
        r_off       <= result[1:0];
        r_load_type <= load_type;
        r_resp      <= 2'b00;
      end
      if (w_start_wr) begin
        r_wdata   <= w_wdata_fmt;
        r_wstrb   <= w_wstrb_fmt;
        r_aw_pend <= 1'b1;
        r_w_pend  <= 1'b1;
      end
      if (w_start_trap) begin
        r_resp <= 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
        r_mis  <= 1'b1;
`endif
      end
      if (r_state == StWr) begin
        if (m_awready) r_aw_pend <= 1'b0;
        if (m_wready)  r_w_pend  <= 1'b0;
      end
      if ((r_state == StWb) && m_bvalid) begin
        r_resp <= m_bresp;
      end
      if ((r_state == StRd) && m_rvalid) begin
        r_resp     <= m_rresp;
        // A read that returns an error yields zero, whatever the load type.
        r_rword    <= (m_rresp == 2'b00) ? m_rdata : 32'h0;
        r_rd_off   <= r_off;
        r_rd_ltype <= r_load_type;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      if (r_state == StDone) r_mis <= 1'b0;
`endif
    end
  end

  // Load formatting from the captured word
  assign w_shift = r_rword >> {r_rd_off, 3'b000};
  assign w_half  = r_rd_off[1] ? r_rword[31:16] : r_rword[15:0];

  // Selects the byte or halfword, then sign- or zero-extends it as the load type requires.
  always_comb begin
    read_data = r_rword;
    case (r_rd_ltype)
      LdLb:    read_data = {{24{w_shift[7]}}, w_shift[7:0]};
      LdLh:    read_data = {{16{w_half[15]}}, w_half};
      LdLbu:   read_data = {24'h0, w_shift[7:0]};
      LdLhu:   read_data = {16'h0, w_half};
      default: read_data = r_rword;
    endcase
  end

  // Pipeline and bus outputs
  assign calculated_result = result;
  assign stall     = rst && ((r_state == StIdle) ? (mem_read | mem_write) : (r_state != StDone));
  assign bus_error = (r_state == StDone) && (r_resp != 2'b00);

  assign m_awaddr  = {r_addr, 2'b00};
  assign m_araddr  = {r_addr, 2'b00};
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_awvalid = (r_state == StWr) && r_aw_pend;
  assign m_wvalid  = (r_state == StWr) && r_w_pend;
  assign m_bready  = (r_state == StWb);
  assign m_arvalid = (r_state == StRa);
  assign m_rready  = (r_state == StRd);

endmodule

// File: tb/tb_mem_stage_axi.sv
// Directed testbench for mem_stage_axi. It contains a small AXI4-Lite slave with
// programmable ready/valid delays.
module tb_mem_stage_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] result = 32'h0;
  logic [31:0] op2_data = 32'h0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [2:0]  load_type = 3'b000;
  logic [31:0] read_data, calculated_result;
  logic        stall, bus_error, misaligned;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  int n_checks = 0;
  int n_fail = 0;

  // Slave configuration and monitors
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  logic [31:0] last_awaddr = 32'h0, last_araddr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  always #5 clk = ~clk;

  mem_stage_axi #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .result(result), .op2_data(op2_data),
    .mem_write(mem_write), .mem_read(mem_read), .store_type(store_type),
    .load_type(load_type), .read_data(read_data), .calculated_result(calculated_result),
    .stall(stall), .bus_error(bus_error), .misaligned(misaligned),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
  assign m_wready  = m_wvalid && (w_cnt >= w_delay);
  assign m_bvalid  = m_bready && (b_cnt >= b_delay);
  assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
  assign m_rvalid  = m_rready && (r_cnt >= r_delay);
  assign m_rdata   = m_rvalid ? s_rdata : 32'h0;
  assign m_rresp   = s_rresp;
  assign m_bresp   = s_bresp;

  always @(posedge clk) begin
    aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
    b_cnt  <= (m_bready && !m_bvalid) ? b_cnt + 1 : 0;
    ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (m_rready && !m_rvalid) ? r_cnt + 1 : 0;
    if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; last_awaddr <= m_awaddr; end
    if (m_wvalid && m_wready) begin
      w_hs <= w_hs + 1; last_wdata <= m_wdata; last_wstrb <= m_wstrb;
    end
    if (m_bvalid && m_bready) b_hs <= b_hs + 1;
    if (m_arvalid && m_arready) begin ar_hs <= ar_hs + 1; last_araddr <= m_araddr; end
    if (m_rvalid && m_rready) r_hs <= r_hs + 1;
  end

  // Presents one access and counts the stalled cycles. Returns at the negedge where stall is low.
  task automatic run_op(input logic wr, input logic [1:0] st, input logic [2:0] lt,
                        input logic [31:0] addr, input logic [31:0] data, output int ncyc);
    @(negedge clk);
    mem_write = wr; mem_read = !wr; store_type = st; load_type = lt;
    result = addr; op2_data = data;
    #1;
    ncyc = 0;
    while (stall && ncyc < 50) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic clear_op();
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] vr;
    repeat (2) @(negedge clk);
    vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    n_checks++; if (vr !== 5'b0) begin n_fail++; $display("FAIL reset_valids: got %b expected 00000", vr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (bus_error !== 1'b0 || misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b%b expected 00", bus_error, misaligned);
    end
    n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h expected 00000000", read_data); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw();
    int n; int aw0; int b0;
    aw0 = aw_hs; b0 = b_hs;
    run_op(1'b1, 2'b10, 3'b000, 32'h104, 32'hDEADBEEF, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d expected 3", n); end
    n_checks++; if (last_awaddr !== 32'h104) begin n_fail++; $display("FAIL sw_awaddr: got %h expected 00000104", last_awaddr); end
    n_checks++; if (last_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", last_wdata); end
    n_checks++; if (last_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb: got %b expected 1111", last_wstrb); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL sw_bus_error: got %b expected 0", bus_error); end
    n_checks++; if (calculated_result !== 32'h104) begin n_fail++; $display("FAIL sw_calc_result: got %h expected 00000104", calculated_result); end
    clear_op();
    repeat (2) @(negedge clk);
    n_checks++; if (aw_hs - aw0 !== 1 || b_hs - b0 !== 1) begin
      n_fail++; $display("FAIL sw_single_txn: got aw %0d b %0d expected 1 1", aw_hs - aw0, b_hs - b0);
    end
  endtask

  task automatic test_sb_lb();
    int n;
    run_op(1'b1, 2'b00, 3'b000, 32'h203, 32'h000000A5, n);
    clear_op();
    n_checks++; if (last_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", last_wdata); end
    n_checks++; if (last_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb: got %b expected 1000", last_wstrb); end
    n_checks++; if (last_awaddr !== 32'h200) begin n_fail++; $display("FAIL sb_awaddr: got %h expected 00000200", last_awaddr); end
    s_rdata = 32'hA5000000;
    run_op(1'b0, 2'b00, 3'b000, 32'h203, 32'h0, n);
    clear_op();
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 3", n); end
    n_checks++; if (last_araddr !== 32'h200) begin n_fail++; $display("FAIL lb_araddr: got %h expected 00000200", last_araddr); end
    n_checks++; if (read_data !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_read_data: got %h expected ffffffa5", read_data); end
    run_op(1'b0, 2'b00, 3'b011, 32'h203, 32'h0, n);
    clear_op();
    n_checks++; if (read_data !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_read_data: got %h expected 000000a5", read_data); end
  endtask

  task automatic test_lh_delay();
    int n;
    ar_delay = 4;
    s_rdata = 32'h80011234;
    run_op(1'b0, 2'b00, 3'b001, 32'h002, 32'h0, n);
    clear_op();
    ar_delay = 0;
    // 1 IDLE + 5 AR cycles (ready after 4 waits) + 1 R cycle
    n_checks++; if (n !== 7) begin n_fail++; $display("FAIL lh_stall_cycles: got %0d expected 7", n); end
    n_checks++; if (read_data !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_read_data: got %h expected ffff8001", read_data); end
  endtask

  task automatic test_reset_mid();
    int k; int r0;
    logic [4:0] vr;
    r_delay = 20;
    s_rdata = 32'h11111111;
    @(negedge clk);
    mem_read = 1'b1; load_type = 3'b010; result = 32'h40;
    k = 0;
    while (!m_rready && k < 10) begin k++; @(negedge clk); end
    n_checks++; if (m_rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_rd: got %b expected 1", m_rready); end
    r0 = r_hs;
    #2 rst = 1'b0;
    #1;
    vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    n_checks++; if (vr !== 5'b0) begin n_fail++; $display("FAIL rstmid_valids: got %b expected 00000", vr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
    n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_read_data: got %h expected 00000000", read_data); end
    clear_op();
    r_delay = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (r_hs !== r0 || m_rready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_handshake: got %0d/%b expected %0d/0", r_hs, m_rready, r0);
    end
  endtask

  task automatic test_w_before_aw();
    int n; int aw0; int w0; int b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    aw_delay = 2;
    @(negedge clk);
    mem_write = 1'b1; store_type = 2'b10; result = 32'h300; op2_data = 32'h12345678;
    @(negedge clk);
    n_checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin n_fail++; $display("FAIL wfirst_both_valid: got %b expected 11", {m_awvalid, m_wvalid}); end
    @(negedge clk);
    n_checks++; if ({m_awvalid, m_wvalid} !== 2'b10) begin n_fail++; $display("FAIL wfirst_w_dropped: got %b expected 10", {m_awvalid, m_wvalid}); end
    n = 2;
    while (stall && n < 50) begin n++; @(negedge clk); end
    clear_op();
    aw_delay = 0;
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL wfirst_stall_cycles: got %0d expected 5", n); end
    repeat (3) @(negedge clk);
    n_checks++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1) begin
      n_fail++; $display("FAIL wfirst_counts: got aw %0d w %0d b %0d expected 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
  endtask

  task automatic test_errors();
    int n;
    s_rresp = 2'b10;
    s_rdata = 32'h12345678;
    run_op(1'b0, 2'b00, 3'b010, 32'h010, 32'h0, n);
    clear_op();
    s_rresp = 2'b00;
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL rerr_bus_error: got %b expected 1", bus_error); end
    n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rerr_read_data: got %h expected 00000000", read_data); end
    @(negedge clk);
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rerr_pulse_end: got %b expected 0", bus_error); end
    s_bresp = 2'b11;
    run_op(1'b1, 2'b10, 3'b000, 32'h020, 32'h1, n);
    clear_op();
    s_bresp = 2'b00;
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL berr_bus_error: got %b expected 1", bus_error); end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    int n; int ar0;
    s_rdata = 32'hCAFEF00D;
    run_op(1'b0, 2'b00, 3'b010, 32'h100, 32'h0, n);
    clear_op();
    n_checks++; if (read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw_read_data: got %h expected cafef00d", read_data); end
    ar0 = ar_hs;
    s_rdata = 32'h0BADF00D;
    run_op(1'b0, 2'b00, 3'b010, 32'h101, 32'h0, n);
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL mis_stall_cycles: got %0d expected 1", n); end
    n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", misaligned); end
    n_checks++; if (ar_hs !== ar0) begin n_fail++; $display("FAIL mis_no_ar: got %0d expected %0d", ar_hs, ar0); end
    n_checks++; if (read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_read_data: got %h expected cafef00d", read_data); end
`else
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL mis_stall_cycles: got %0d expected 3", n); end
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b expected 0", misaligned); end
    n_checks++; if (ar_hs !== ar0 + 1 || last_araddr !== 32'h100) begin
      n_fail++; $display("FAIL mis_araddr: got %0d/%h expected %0d/00000100", ar_hs, last_araddr, ar0 + 1);
    end
    n_checks++; if (read_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL mis_read_data: got %h expected 0badf00d", read_data); end
`endif
    clear_op();
    @(negedge clk);
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b expected 0", misaligned); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lb();
    test_lh_delay();
    test_reset_mid();
    test_w_before_aw();
    test_errors();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
